// File: rtl/afe_att_spi_ctrl.sv
// afe_att_spi_ctrl
// Write-only SPI shifter for the two AFE attenuator chains. A single CSR
// write selects an AFE and a data word. The word is shifted out MSB first
// on that AFE's SCLK/SDI pair and then latched with one LE pulse. Busy,
// overrun and the last accepted word are reported back through status.
module afe_att_spi_ctrl #(
    parameter int CLK_RATE     = 99999001,
    parameter int SPI_CLK_RATE = 5000000,
    parameter int SHIFT_WIDTH  = 8
) (
    input  logic        sysClk,
    input  logic        sysReset,
    input  logic        sysCsrStrobe,
    input  logic [31:0] GPIO_OUT,
    output logic [31:0] status,
    output logic [1:0]  AFE_SPI_CLK,
    output logic [1:0]  AFE_SPI_SDI,
    output logic [1:0]  AFE_SPI_LE
);

    // sysClk cycles per SCLK half period, rounded up so SCLK never exceeds
    // SPI_CLK_RATE, and never below 2 so each SCLK phase lasts at least two cycles.
    localparam longint HALF_RAW   = (longint'(CLK_RATE) + 64'sd2 * longint'(SPI_CLK_RATE) - 64'sd1)
                                    / (64'sd2 * longint'(SPI_CLK_RATE));
    localparam int     HALF_TICKS = (HALF_RAW < 64'sd2) ? 32'sd2 : int'(HALF_RAW);
    localparam int     CNT_W      = $clog2(HALF_TICKS);
    localparam int     BIT_W      = (SHIFT_WIDTH > 32'sd1) ? $clog2(SHIFT_WIDTH) : 32'sd1;

    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(HALF_TICKS - 32'sd1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(32'sd0);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(32'sd1);
    localparam logic [BIT_W-1:0] BIT_FIRST  = BIT_W'(SHIFT_WIDTH - 32'sd1);
    localparam logic [BIT_W-1:0] BIT_ZERO   = BIT_W'(32'sd0);
    localparam logic [BIT_W-1:0] BIT_ONE    = BIT_W'(32'sd1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SHIFT    = 3'd1,
        ST_LE_SETUP = 3'd2,
        ST_LE_PULSE = 3'd3,
        ST_LE_HOLD  = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [BIT_W-1:0]       bit_q, bit_d;
    logic [SHIFT_WIDTH-1:0] shreg_q, shreg_d;
    logic                   sclk_q, sclk_d;
    logic                   busy_q, busy_d;
    logic                   overrun_q, overrun_d;
    logic                   tgt_q, tgt_d;
    logic [SHIFT_WIDTH-1:0] data_q, data_d;
    logic [1:0]             afe_clk_q, afe_clk_d;
    logic [1:0]             afe_sdi_q, afe_sdi_d;
    logic [1:0]             afe_le_q, afe_le_d;

    logic                   cnt_done_s;
    logic                   is_ctrl_s;
    logic                   sdi_s;
    logic                   le_s;
    logic [1:0]             tgt_sel_s;
    logic [23:0]            data_ext_s;
    logic                   unused_gpio_s;

    // Next-state logic: command decode, phase timer, bit shifting and pin steering.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shreg_d   = shreg_q;
        sclk_d    = sclk_q;
        busy_d    = busy_q;
        overrun_d = overrun_q;
        tgt_d     = tgt_q;
        data_d    = data_q;

        cnt_done_s = (cnt_q == CNT_ZERO);
        is_ctrl_s  = GPIO_OUT[31];

        // Overrun: a control write clears it; a transfer write while busy sets it.
        if (sysCsrStrobe) begin
            if (is_ctrl_s) begin
                overrun_d = 1'b0;
            end else if (busy_q) begin
                overrun_d = 1'b1;
            end else begin
                overrun_d = overrun_q;
            end
        end else begin
            overrun_d = overrun_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (sysCsrStrobe && !is_ctrl_s) begin
                    state_d = ST_SHIFT;
                    cnt_d   = CNT_RELOAD;
                    bit_d   = BIT_FIRST;
                    shreg_d = GPIO_OUT[SHIFT_WIDTH-1:0];
                    sclk_d  = 1'b0;
                    busy_d  = 1'b1;
                    tgt_d   = GPIO_OUT[24];
                    data_d  = GPIO_OUT[SHIFT_WIDTH-1:0];
                end else begin
                    busy_d  = 1'b0;
                    sclk_d  = 1'b0;
                end
            end
            ST_SHIFT: begin
                if (cnt_done_s) begin
                    cnt_d = CNT_RELOAD;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else begin
                        // Falling SCLK edge: move on to the next bit.
                        sclk_d  = 1'b0;
                        shreg_d = shreg_q << 1'b1;
                        if (bit_q == BIT_ZERO) begin
                            state_d = ST_LE_SETUP;
                        end else begin
                            bit_d = bit_q - BIT_ONE;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_LE_SETUP: begin
                if (cnt_done_s) begin
                    state_d = ST_LE_PULSE;
                    cnt_d   = CNT_RELOAD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_LE_PULSE: begin
                if (cnt_done_s) begin
                    state_d = ST_LE_HOLD;
                    cnt_d   = CNT_RELOAD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_LE_HOLD: begin
                if (cnt_done_s) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                sclk_d  = 1'b0;
            end
        endcase

        // Pin levels follow the next state so the outputs can be registered
        // without adding a cycle of latency.
        if (state_d == ST_SHIFT) begin
            sdi_s = shreg_d[SHIFT_WIDTH-1];
        end else begin
            sdi_s = 1'b0;
        end
        le_s = (state_d == ST_LE_PULSE);

        // Only the addressed AFE sees any activity.
        if (tgt_d) begin
            tgt_sel_s = 2'b10;
        end else begin
            tgt_sel_s = 2'b01;
        end
        afe_clk_d = tgt_sel_s & {2{sclk_d}};
        afe_sdi_d = tgt_sel_s & {2{sdi_s}};
        afe_le_d  = tgt_sel_s & {2{le_s}};
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge sysClk) begin
        if (sysReset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= CNT_ZERO;
            bit_q     <= BIT_ZERO;
            shreg_q   <= {SHIFT_WIDTH{1'b0}};
            sclk_q    <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
            tgt_q     <= 1'b0;
            data_q    <= {SHIFT_WIDTH{1'b0}};
            afe_clk_q <= 2'b00;
            afe_sdi_q <= 2'b00;
            afe_le_q  <= 2'b00;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shreg_q   <= shreg_d;
            sclk_q    <= sclk_d;
            busy_q    <= busy_d;
            overrun_q <= overrun_d;
            tgt_q     <= tgt_d;
            data_q    <= data_d;
            afe_clk_q <= afe_clk_d;
            afe_sdi_q <= afe_sdi_d;
            afe_le_q  <= afe_le_d;
        end
    end

    assign data_ext_s    = 24'(data_q);
    assign status        = {busy_q, overrun_q, 5'b00000, tgt_q, data_ext_s};
    assign AFE_SPI_CLK   = afe_clk_q;
    assign AFE_SPI_SDI   = afe_sdi_q;
    assign AFE_SPI_LE    = afe_le_q;

    // Command bits this block does not decode.
    assign unused_gpio_s = ^{GPIO_OUT[30:25], GPIO_OUT[23:0]};

endmodule

// File: doc/afe_att_spi_ctrl.md
Name: afe_att_spi_ctrl

Overview:
- Write-only SPI shifter that loads the two AFE attenuator chains through the AFE_SPI_CLK/SDI/LE board pins.
- Sits inside common_dsbpm_top, directly upstream of those pins; the only thing driving them.
- Commanded by a single CSR/GPIO write from the processor on sysClk; reports busy/overrun/last-word status back over the same CSR path.

Parameters:
- CLK_RATE, 99999001, sysClk frequency in Hz.
- SPI_CLK_RATE, 5000000, maximum SCLK frequency in Hz.
- SHIFT_WIDTH, 8, bits per attenuator word (1..24).
- HALF_TICKS (localparam) = max(2, ceil(CLK_RATE/(2*SPI_CLK_RATE))) sysClk cycles per SCLK half-period; evaluates to 10 at the defaults.

Ports:
- sysClk  in  1  sole clock.
- sysReset  in  1  synchronous, active-high reset.
- sysCsrStrobe  in  1  one-cycle write strobe.
- GPIO_OUT  in  32  write data, sampled when sysCsrStrobe=1.
- status  out  32  readback word.
- AFE_SPI_CLK  out  2  SCLK per AFE, idle low.
- AFE_SPI_SDI  out  2  serial data per AFE, MSB first.
- AFE_SPI_LE  out  2  latch enable per AFE, active high.

Behaviour:
- Interface: one clock, sysClk; sysReset is synchronous and active-high.
- Reset: all AFE_SPI_* outputs 0; status 0 (busy 0, overrun 0, last target 0, last data 0); FSM returns to IDLE.
- Reset mid-transfer: outputs read 0 on the next edge and LE is never asserted.
- Command decode on a strobe:
  - GPIO_OUT[31]=1 is a control write: clear overrun, start no transfer.
  - Otherwise it is a transfer: data = GPIO_OUT[SHIFT_WIDTH-1:0], target = GPIO_OUT[24] (0 selects AFE 0, 1 selects AFE 1).
  - A transfer strobe while busy is dropped and sets overrun (sticky).
  - A control write while busy clears overrun and does not disturb the transfer in progress.
- Accepted transfer:
  - Data goes into a shift register; target and data are latched into status.
  - busy=1 from the cycle after the strobe until IDLE is re-entered.
- FSM states: IDLE -> SHIFT -> LE_SETUP -> LE_PULSE -> LE_HOLD -> IDLE.
  - One HALF_TICKS down-counter times every state.
- SHIFT, per bit, MSB first:
  - SDI presents the bit while SCLK is low for HALF_TICKS cycles, then SCLK is high for HALF_TICKS cycles.
  - The shift register advances on the SCLK falling edge.
  - After SHIFT_WIDTH bits, SCLK=0 and SDI=0.
- LE_SETUP: HALF_TICKS cycles with all lines low.
- LE_PULSE: HALF_TICKS cycles with LE=1.
- LE_HOLD: HALF_TICKS cycles with all lines low; then IDLE and busy=0.
- Timing:
  - First SDI bit is valid 1 cycle after the strobe; first SCLK rise is at 1+HALF_TICKS.
  - Total busy time = (2*SHIFT_WIDTH+3)*HALF_TICKS cycles, i.e. 190 at the defaults.
- Only the targeted AFE's CLK/SDI/LE toggle; the other AFE's lines stay 0 throughout.
- A strobe on the same cycle that busy drops (the last LE_HOLD tick) counts as busy: the write is dropped and overrun is set. A strobe on the following cycle is accepted.
- status layout: [31] busy, [30] overrun, [24] last target, [SHIFT_WIDTH-1:0] last accepted data, all other bits 0.
- status is registered and updates the cycle after the event that changes it.

Test Plan:
- Defaults; write 0x000000A5 -> AFE0 SDI bits 1,0,1,0,0,1,0,1 sampled on 8 SCLK rises at cycles 11,31,...,151; LE0 high for cycles 171-180; busy clears at cycle 191; status=0x000000A5; AFE1 lines stay 0.
- Write 0x0100003C -> only AFE1 toggles, shifting bits 00111100; afterwards status=0x0100003C.
- Write 0x00000011, then a second transfer 40 cycles later -> second write ignored, only 0x11 shifted; afterwards status=0x40000011. Then write 0x80000000 -> status=0x00000011.
- Strobe exactly on the last busy cycle -> dropped, overrun set; repeat one cycle later -> accepted, full transfer.
- Assert sysReset at cycle 50 of a transfer -> all outputs 0 next cycle, no LE pulse, status=0; a new write afterwards completes normally.
- CLK_RATE=100000000, SPI_CLK_RATE=60000000 -> HALF_TICKS=2; SCLK period 4 cycles; busy = 38 cycles for 8 bits.
